p2_regfile: RTL

Parametrised general-purpose register file for the SIMPLE-family processor core, sitting between the instruction decoder and the ALU stage. It supports configurable data width and register count, and captures two source operands into registered outputs on a decode strobe. It writes back one result per cycle and keeps a per-register busy scoreboard so the sequencer can stall on read-after-write hazards. An optional bypass forwards same-cycle write-back data to the operand registers.

---
 rtl/p2_regfile_pkg.sv | 27 ++
 rtl/p2_regfile_rdport.sv | 61 ++++++
 rtl/p2_regfile.sv | 114 +++++++++++
 3 files changed

// File: rtl/p2_regfile_pkg.sv
// Shared constants, typedefs and decode-state encodings for the SIMPLE-family register file.
// Latency: none (package only).
// Backpressure: none (package only).
package p2_pkg;

    localparam int P2_DW   = 16;
    localparam int P2_NREG = 8;
    localparam int P2_AW   = $clog2(P2_NREG);

    typedef logic [P2_DW-1:0] word_t;
    typedef logic [P2_AW-1:0] reg_addr_t;

    // Decode sequencer states; the sequencer sits in DEC_STALL while hazard is high.
    typedef enum logic [1:0] {
        DEC_IDLE  = 2'd0,
        DEC_ISSUE = 2'd1,
        DEC_STALL = 2'd2,
        DEC_FLUSH = 2'd3
    } dec_state_t;

    // True when an address names a real, writable register.
    function automatic logic addr_ok(input int unsigned addr, input int unsigned nreg,
                                     input logic zero_r0);
        return (addr < nreg) && !(zero_r0 && (addr == 0));
    endfunction

endpackage

// File: rtl/p2_regfile_rdport.sv
// One read port: register select, range check, optional write-back bypass (P2_REGFILE_BYPASS_EN).
// Latency: purely combinational; the top registers the result.
// Backpressure: reports whether the selected source is still reserved so the top can stall.
module p2_regfile_rdport
    import p2_pkg::*;
#(
    parameter int DW      = P2_DW,
    parameter int NREG    = P2_NREG,
    parameter int ZERO_R0 = 0,
    localparam int AW     = $clog2(NREG)
) (
    input  logic [NREG*DW-1:0] regs,
    input  logic [NREG-1:0]    busy,
    input  logic [AW-1:0]      addr,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [DW-1:0]      wr_data,
    output logic [DW-1:0]      rd_data,
    output logic               src_busy
);

    logic [DW-1:0] sel_data;
    logic          sel_busy;

    // Select the addressed register; addresses past NREG match nothing and read as zero.
    always_comb begin
        sel_data = '0;
        sel_busy = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (addr == AW'(i)) begin
                sel_data = regs[i*DW +: DW];
                sel_busy = busy[i];
            end
        end
        if ((ZERO_R0 != 0) && (addr == '0)) begin
            sel_data = '0;
            sel_busy = 1'b0;
        end
    end

`ifdef P2_REGFILE_BYPASS_EN
    logic byp;

    // A same-cycle write to this source supplies the operand and satisfies its reservation.
    always_comb begin
        byp      = wr_en && (wr_addr == addr) && addr_ok(32'(addr), NREG, ZERO_R0 != 0);
        rd_data  = byp ? wr_data : sel_data;
        src_busy = sel_busy & ~byp;
    end
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_addr, wr_data};

    // No forwarding: the operand is the stored value and busy is taken as-is.
    always_comb begin
        rd_data  = sel_data;
        src_busy = sel_busy;
    end
`endif

endmodule

// File: rtl/p2_regfile.sv
// Register file with busy scoreboard and two registered operand ports; bypass via P2_REGFILE_BYPASS_EN.
// Latency: operands appear 1 cycle after rd_en; writes are readable the following cycle.
// Backpressure: hazard blocks rd_en while a source is reserved; ar/br hold until it clears.
module p2_regfile
    import p2_pkg::*;
#(
    parameter int DW      = P2_DW,
    parameter int NREG    = P2_NREG,
    parameter int NDBG    = 4,
    parameter int ZERO_R0 = 0,
    localparam int AW     = $clog2(NREG)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               rd_en,
    input  logic [AW-1:0]      rs,
    input  logic [AW-1:0]      rd,
    output logic [DW-1:0]      ar,
    output logic [DW-1:0]      br,
    output logic               hazard,
    input  logic               rsv_en,
    input  logic [AW-1:0]      rsv_addr,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [DW-1:0]      wr_data,
    output logic [NREG-1:0]    busy,
    output logic [NDBG*DW-1:0] dbg_regs
);

    logic [NREG*DW-1:0] regs_q;
    logic [NREG-1:0]    busy_q;
    logic [NREG-1:0]    wr_sel;
    logic [NREG-1:0]    rsv_sel;
    logic [DW-1:0]      a_data;
    logic [DW-1:0]      b_data;
    logic               a_busy;
    logic               b_busy;

    // One-hot decode of write and reserve targets; out-of-range and protected r0 decode to nothing.
    always_comb begin
        wr_sel  = '0;
        rsv_sel = '0;
        for (int i = 0; i < NREG; i++) begin
            wr_sel[i]  = wr_en  && (wr_addr  == AW'(i)) && addr_ok(i, NREG, ZERO_R0 != 0);
            rsv_sel[i] = rsv_en && (rsv_addr == AW'(i)) && addr_ok(i, NREG, ZERO_R0 != 0);
        end
    end

    // Register array write-back.
    always_ff @(posedge clock) begin
        if (reset) begin
            regs_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_sel[i]) begin
                    regs_q[i*DW +: DW] <= wr_data;
                end
            end
        end
    end

    // Scoreboard: a reservation wins over a same-cycle write because it belongs to a newer writer.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (rsv_sel[i]) begin
                    busy_q[i] <= 1'b1;
                end else if (wr_sel[i]) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    p2_regfile_rdport #(.DW(DW), .NREG(NREG), .ZERO_R0(ZERO_R0)) u_rdport_a (
        .regs     (regs_q),
        .busy     (busy_q),
        .addr     (rs),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_data  (a_data),
        .src_busy (a_busy)
    );

    p2_regfile_rdport #(.DW(DW), .NREG(NREG), .ZERO_R0(ZERO_R0)) u_rdport_b (
        .regs     (regs_q),
        .busy     (busy_q),
        .addr     (rd),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_data  (b_data),
        .src_busy (b_busy)
    );

    assign hazard   = rd_en & (a_busy | b_busy);
    assign busy     = busy_q;
    assign dbg_regs = regs_q[NDBG*DW-1:0];

    // Operand capture: load on an unblocked decode strobe, otherwise hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            ar <= '0;
            br <= '0;
        end else if (rd_en && !hazard) begin
            ar <= a_data;
            br <= b_data;
        end
    end

endmodule
